// File: rtl/codec_config_pkg.sv
// Shared types for the audio codec power-up configurator.
//   opcode_e : table entry opcode (WRITE, DELAY, END; 2'b11 is decoded as END)
//   state_e  : sequencer FSM states
//   entry_t  : 18-bit table entry {opcode, reg_addr, data}
// The helper functions build entries so the ROM table reads like a script.
package codec_config_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_END   = 2'b10
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RSP,
    S_DELAY,
    S_FINISH,
    S_FAIL
  } state_e;

  typedef struct packed {
    opcode_e    opcode;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } entry_t;

  function automatic entry_t op_write(input logic [7:0] reg_addr, input logic [7:0] data);
    return '{opcode: OP_WRITE, reg_addr: reg_addr, data: data};
  endfunction

  function automatic entry_t op_delay(input logic [15:0] ticks);
    return '{opcode: OP_DELAY, reg_addr: ticks[15:8], data: ticks[7:0]};
  endfunction

  function automatic entry_t op_end();
    return '{opcode: OP_END, reg_addr: 8'h00, data: 8'h00};
  endfunction

  // A DELAY entry reuses the reg/data fields as a 16-bit tick count.
  function automatic logic [15:0] delay_ticks(input entry_t e);
    return {e.reg_addr, e.data};
  endfunction

endpackage

// File: rtl/codec_config_rom.sv
// Codec initialisation script, one entry per address.
// Ports:
//   addr  : entry index
//   entry : combinational table entry at addr (unlisted addresses read END)
// Edit this file alone to change the codec bring-up sequence.
module codec_config_rom
  import codec_config_pkg::*;
#(
  parameter int unsigned ENTRIES = 32,
  localparam int unsigned IDX_W = $clog2(ENTRIES)
) (
  input  logic [IDX_W-1:0] addr,
  output entry_t           entry
);

  // NOTE: a case-decoded constant table is pure logic with no storage, so it
  // needs no reset and no clock; the read is combinational from addr.
  always_comb begin
    entry = op_end();
    case (int'(addr))
      0:       entry = op_write(8'h00, 8'h00);  // select register page 0
      1:       entry = op_write(8'h01, 8'h01);  // software reset
      2:       entry = op_delay(16'd3);         // let the codec come out of reset
      3:       entry = op_write(8'h07, 8'h0A);  // codec datapath: L->L, R->R DACs
      4:       entry = op_delay(16'd0);         // spare settle slot, currently no wait
      5:       entry = op_write(8'h0F, 8'h00);  // left ADC PGA unmuted, 0 dB
      default: entry = op_end();
    endcase
  end

endmodule

// File: rtl/codec_config_sequencer.sv
// Autonomous power-up configurator for the audio codec.
// Walks codec_config_rom and turns each WRITE entry into one request to the
// shared transaction-level I2C master; DELAY entries wait ticks*DELAY_UNIT.
// Ports:
//   clk, reset (async, active-low), start (re-run pulse, honoured when idle)
//   busy, done, error, errorIndex : status to the SoC
//   busOwned                      : top-level mux select for the audio I2C line
//   reqValid/reqReady/reqAddr/reqReg/reqData : write request to the I2C master
//   rspValid/rspNack              : transaction-complete pulse and NACK flag
module codec_config_sequencer
  import codec_config_pkg::*;
#(
  parameter int unsigned ENTRIES        = 32,
  parameter logic [6:0]  DEV_ADDR       = 7'h18,
  parameter int unsigned STARTUP_CYCLES = 500000,
  parameter int unsigned DELAY_UNIT     = 50000,
  parameter int unsigned RETRIES        = 3,
  localparam int unsigned IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] errorIndex,
  output logic             busOwned,
  output logic             reqValid,
  input  logic             reqReady,
  output logic [6:0]       reqAddr,
  output logic [7:0]       reqReg,
  output logic [7:0]       reqData,
  input  logic             rspValid,
  input  logic             rspNack
);

  localparam int unsigned START_W = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned UNIT_W  = $clog2(DELAY_UNIT + 1);
  localparam int unsigned RETRY_W = $clog2(RETRIES + 1);

  state_e             state, next_state;
  entry_t             entry;
  logic [IDX_W-1:0]   index;
  logic [RETRY_W-1:0] retry_cnt;
  logic [START_W-1:0] startup_cnt;
  // Two-level delay count: ticks_left holds the full 16-bit tick value, so
  // ticks=16'hFFFF cannot overflow.
  logic [UNIT_W-1:0]  unit_cnt;
  logic [15:0]        ticks_left;
  logic               active;
  logic               last_entry, startup_done, delay_last, advance;

  codec_config_rom #(.ENTRIES(ENTRIES)) u_rom (
    .addr  (index),
    .entry (entry)
  );

  assign last_entry   = (index == IDX_W'(ENTRIES - 1));
  assign startup_done = (startup_cnt == START_W'(STARTUP_CYCLES - 1));
  assign delay_last   = (ticks_left == 16'd1) && (unit_cnt == UNIT_W'(DELAY_UNIT - 1));

  assign busy     = active;
  assign busOwned = active;
  assign reqValid = (state == S_ISSUE);
  assign reqAddr  = DEV_ADDR;

  // Reset lands directly in WAIT_START so the sequence runs after power-up
  // without a start pulse; busy/busOwned follow one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_WAIT_START;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      S_IDLE:       if (start) next_state = S_WAIT_START;
      S_WAIT_START: if (startup_done) next_state = S_FETCH;
      S_FETCH: begin
        case (entry.opcode)
          OP_WRITE: next_state = S_ISSUE;
          OP_DELAY: begin
            if (delay_ticks(entry) == 16'd0) begin
              advance    = 1'b1;
              next_state = last_entry ? S_FINISH : S_FETCH;
            end else begin
              next_state = S_DELAY;
            end
          end
          default:  next_state = S_FINISH;  // OP_END and the unused 2'b11
        endcase
      end
      S_ISSUE:      if (reqReady) next_state = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (rspValid) begin
          if (!rspNack) begin
            advance    = 1'b1;
            next_state = last_entry ? S_FINISH : S_FETCH;
          end else if (retry_cnt < RETRY_W'(RETRIES)) begin
            next_state = S_ISSUE;
          end else begin
            next_state = S_FAIL;
          end
        end
      end
      S_DELAY: begin
        if (delay_last) begin
          advance    = 1'b1;
          next_state = last_entry ? S_FINISH : S_FETCH;
        end
      end
      default:      next_state = S_IDLE;    // FINISH, FAIL
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index       <= '0;
      retry_cnt   <= '0;
      startup_cnt <= '0;
      unit_cnt    <= '0;
      ticks_left  <= '0;
      active      <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      errorIndex  <= '0;
      reqReg      <= '0;
      reqData     <= '0;
    end else begin
      active <= !(next_state inside {S_IDLE, S_FINISH, S_FAIL});

      case (state)
        S_IDLE: begin
          if (start) begin
            done        <= 1'b0;
            error       <= 1'b0;
            index       <= '0;
            retry_cnt   <= '0;
            startup_cnt <= '0;
          end
        end
        S_WAIT_START: startup_cnt <= startup_cnt + 1'b1;
        S_FETCH: begin
          if (entry.opcode == OP_WRITE) begin
            reqReg  <= entry.reg_addr;
            reqData <= entry.data;
          end
          ticks_left <= delay_ticks(entry);
          unit_cnt   <= '0;
        end
        S_WAIT_RSP: if (rspValid && rspNack) retry_cnt <= retry_cnt + 1'b1;
        S_DELAY: begin
          if (unit_cnt == UNIT_W'(DELAY_UNIT - 1)) begin
            unit_cnt   <= '0;
            ticks_left <= ticks_left - 16'd1;
          end else begin
            unit_cnt <= unit_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      // The last table slot finishes instead of wrapping back to entry 0.
      if (advance) begin
        retry_cnt <= '0;
        if (!last_entry) index <= index + 1'b1;
      end

      if (next_state == S_FINISH) done <= 1'b1;
      if (next_state == S_FAIL) begin
        error      <= 1'b1;
        errorIndex <= index;
      end
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with short startup/delay timing.
// ROM script: 0 W 00/00, 1 W 01/01, 2 DELAY 3, 3 W 07/0A, 4 DELAY 0,
//             5 W 0F/00, 6 END.
// Gap = clock edges from the rspValid edge until reqValid is seen high:
//   retry after NACK 0, WRITE->WRITE 1, through DELAY 0 -> 2,
//   through DELAY 3 -> 2 + 3*4 = 14.
module tb_codec_config_sequencer;

  localparam int unsigned ENTRIES        = 32;
  localparam int unsigned STARTUP_CYCLES = 10;
  localparam int unsigned DELAY_UNIT     = 4;
  localparam int unsigned RETRIES        = 3;
  localparam int unsigned IDX_W          = $clog2(ENTRIES);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             reqReady = 1'b0;
  logic             rspValid = 1'b0;
  logic             rspNack = 1'b0;
  logic             busy, done, error, busOwned, reqValid;
  logic [IDX_W-1:0] errorIndex;
  logic [6:0]       reqAddr;
  logic [7:0]       reqReg, reqData;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  codec_config_sequencer #(
    .ENTRIES        (ENTRIES),
    .DEV_ADDR       (7'h18),
    .STARTUP_CYCLES (STARTUP_CYCLES),
    .DELAY_UNIT     (DELAY_UNIT),
    .RETRIES        (RETRIES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .errorIndex (errorIndex),
    .busOwned   (busOwned),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqAddr    (reqAddr),
    .reqReg     (reqReg),
    .reqData    (reqData),
    .rspValid   (rspValid),
    .rspNack    (rspNack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     busy,       0);
    check({tag, "_done"},     done,       0);
    check({tag, "_error"},    error,      0);
    check({tag, "_errIdx"},   errorIndex, 0);
    check({tag, "_owned"},    busOwned,   0);
    check({tag, "_reqValid"}, reqValid,   0);
    check({tag, "_reqReg"},   reqReg,     0);
    check({tag, "_reqData"},  reqData,    0);
    check({tag, "_reqAddr"},  reqAddr,    7'h18);
  endtask

  // Bounded wait for a request; edges counts negedges waited.
  task automatic wait_req(input string tag, output int edges);
    edges = 0;
    while (reqValid !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_valid"}, reqValid, 1);
  endtask

  task automatic accept(input string tag, input logic [7:0] exp_reg, input logic [7:0] exp_data);
    check({tag, "_reg"},  reqReg,  exp_reg);
    check({tag, "_data"}, reqData, exp_data);
    check({tag, "_addr"}, reqAddr, 7'h18);
    reqReady = 1'b1;
    @(negedge clk);
    reqReady = 1'b0;
    check({tag, "_drop"}, reqValid, 0);
  endtask

  // Master response 5 cycles after acceptance.
  task automatic respond(input logic nack);
    repeat (4) @(negedge clk);
    rspValid = 1'b1;
    rspNack  = nack;
    @(negedge clk);
    rspValid = 1'b0;
    rspNack  = 1'b0;
  endtask

  task automatic step(input string tag, input int exp_gap, input logic [7:0] exp_reg,
                      input logic [7:0] exp_data, input logic nack);
    int gap;
    wait_req(tag, gap);
    check({tag, "_gap"}, gap, exp_gap);
    accept(tag, exp_reg, exp_data);
    respond(nack);
  endtask

  task automatic quiet(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (reqValid === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   gap;
    logic stable;

    // Power-on reset, then the automatic run.
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);
    check("boot_busy",  busy,     1);
    check("boot_owned", busOwned, 1);
    // STARTUP_CYCLES+1 edges after release in total; one is already consumed.
    wait_req("boot_first", gap);
    check("boot_gap", gap, STARTUP_CYCLES);

    // Entry 0 held off for 20 cycles; start mid-hold must be ignored.
    check("e0_reg",  reqReg,  8'h00);
    check("e0_data", reqData, 8'h00);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (reqValid !== 1'b1 || reqReg !== 8'h00 || reqData !== 8'h00 || busy !== 1'b1)
        stable = 1'b0;
    end
    check("e0_hold_stable", stable, 1);
    accept("e0", 8'h00, 8'h00);
    respond(1'b0);

    // Entry 1: two NACKs then ACK.
    step("e1_try0", 1, 8'h01, 8'h01, 1'b1);
    step("e1_try1", 0, 8'h01, 8'h01, 1'b1);
    step("e1_try2", 0, 8'h01, 8'h01, 1'b0);
    step("e3",     14, 8'h07, 8'h0A, 1'b0);
    step("e5",      2, 8'h0F, 8'h00, 1'b0);
    @(negedge clk);
    check("run1_done",  done,     1);
    check("run1_busy",  busy,     0);
    check("run1_owned", busOwned, 0);
    check("run1_error", error,    0);
    quiet("run1_quiet");

    // Rerun from idle; entry 3 NACKs on every attempt.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run2_done_clr", done, 0);
    check("run2_busy",     busy, 1);
    // Leaving IDLE costs one edge more than the reset path.
    wait_req("run2_first", gap);
    check("run2_gap", gap, STARTUP_CYCLES + 1);
    accept("run2_e0", 8'h00, 8'h00);
    respond(1'b0);
    step("run2_e1",     1, 8'h01, 8'h01, 1'b0);
    step("run2_e3_t0", 14, 8'h07, 8'h0A, 1'b1);
    step("run2_e3_t1",  0, 8'h07, 8'h0A, 1'b1);
    step("run2_e3_t2",  0, 8'h07, 8'h0A, 1'b1);
    step("run2_e3_t3",  0, 8'h07, 8'h0A, 1'b1);
    check("run2_error",    error,      1);
    check("run2_errIdx",   errorIndex, 3);
    check("run2_done",     done,       0);
    check("run2_busy",     busy,       0);
    check("run2_owned",    busOwned,   0);
    check("run2_reqValid", reqValid,   0);
    quiet("run2_quiet");

    // Restart after error, with a stray response during startup.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run3_err_clr", error, 0);
    rspValid = 1'b1;
    rspNack  = 1'b1;
    @(negedge clk);
    rspValid = 1'b0;
    rspNack  = 1'b0;
    wait_req("run3_first", gap);
    check("run3_gap", gap, STARTUP_CYCLES);
    accept("run3_e0", 8'h00, 8'h00);
    respond(1'b0);
    wait_req("run3_e1", gap);
    check("run3_e1_gap", gap, 1);
    accept("run3_e1", 8'h01, 8'h01);

    // Now in WAIT_RSP: reset between clock edges must clear outputs at once.
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
Autonomous power-up configurator for the on-board audio codec. It walks a fixed table of register writes and delays and issues each write as one I2C transaction through a shared transaction-level I2C master on the audio SCL/SDA line. It asserts bus ownership while active so the top level can keep the SoC's I2C path off that line. It reports done/error status to the SoC.

Parameters:
ENTRIES, 32, number of table entries (index width = $clog2(ENTRIES))
DEV_ADDR, 7'h18, 7-bit I2C slave address of the codec
STARTUP_CYCLES, 500000, clocks to wait after reset/start before the first entry (10 ms at 50 MHz)
DELAY_UNIT, 50000, clocks per delay tick for DELAY entries (1 ms at 50 MHz)
RETRIES, 3, re-issues of a NACKed write before error

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; re-runs the sequence from entry 0 when idle, done or error
busy  output  1  sequence in progress
done  output  1  level; table reached END without error
error  output  1  level; retries exhausted on some entry
errorIndex  output  $clog2(ENTRIES)  index of the failing entry
busOwned  output  1  sequencer owns the audio I2C line (top-level mux select)
reqValid  output  1  write request to the I2C master
reqReady  input  1  master accepts the request
reqAddr  output  7  slave address (DEV_ADDR)
reqReg  output  8  codec register/page address
reqData  output  8  data byte
rspValid  input  1  single-cycle transaction-complete pulse
rspNack  input  1  qualifies rspValid; 1 = any byte NACKed

Behaviour:
- Reset values: busy=0, done=0, error=0, errorIndex=0, busOwned=0, reqValid=0, reqReg=0, reqData=0. reqAddr is constant DEV_ADDR.
- After reset deassertion the FSM starts automatically: state WAIT_START, busy=1, busOwned=1.
- Table entry is 18 bits: [17:16] opcode (00 WRITE, 01 DELAY, 10 END, 11 treated as END), [15:8] reg, [7:0] data. For DELAY, ticks = {reg,data}; 0 ticks = no wait.
- ROM read is combinational from the index register. Entry decode costs zero extra cycles.
- States:
  - IDLE: entered only via done/error.
  - WAIT_START: count STARTUP_CYCLES, then go to FETCH with index=0, retryCnt=0.
  - FETCH: WRITE → ISSUE; DELAY → DELAY; END → FINISH.
  - ISSUE: reqValid=1 with reqReg/reqData registered. reqValid stays high and fields stay stable until reqReady is sampled high; then → WAIT_RSP with reqValid=0 on the next cycle.
  - WAIT_RSP: on rspValid with !rspNack → index+1, retryCnt=0, FETCH. On rspValid with rspNack and retryCnt<RETRIES → retryCnt+1, ISSUE. Otherwise → FAIL.
  - DELAY: ticks×DELAY_UNIT cycles; index+1 → FETCH.
  - FINISH: done=1, busy=0, busOwned=0 → IDLE.
  - FAIL: error=1, errorIndex=index, busy=0, busOwned=0 → IDLE.
- Index reaching ENTRIES-1 without END: after that entry completes, go to FINISH (no wrap).
- start while busy: ignored. start in IDLE: clears done/error, → WAIT_START.
- rspValid outside WAIT_RSP: ignored.
- reqReady and rspValid in the same cycle (master completing with zero latency): the ISSUE handshake completes; the response is then expected in WAIT_RSP. The master guarantees rspValid ≥1 cycle after acceptance.
- busOwned drops only in FINISH/FAIL, never mid-transaction.
- Asynchronous reset mid-transaction aborts immediately. The master is reset by the same signal.
- Counters: delay counter is 16+$clog2(DELAY_UNIT) bits or a two-level tick/unit count; it must not overflow at ticks=16'hFFFF.

Decomposition:
- Package codec_config_pkg: opcode enum (OP_WRITE, OP_DELAY, OP_END), FSM state enum, entry struct {opcode, reg, data}.
- Sub-module codec_config_rom: case-based table indexed by address, ENTRIES deep, outputs the entry struct. Keeping it separate lets the codec init table change without touching the FSM.

Test Plan:
1. Reset release, 3-entry table (WRITE 00/00, WRITE 01/01, END), master acks with 5-cycle latency → exactly two requests in order, done=1, busy=0, busOwned=0 after the second rspValid; the first reqValid appears STARTUP_CYCLES after reset (bench overrides STARTUP_CYCLES=10).
2. reqReady held low 20 cycles → reqValid stays high and reqReg/reqData stay stable, one accept only.
3. NACK on entry 1 twice, then ack, RETRIES=3 → entry 1 issued 3 times, sequence completes, error=0.
4. NACK on entry 2 four times → 4 issues, error=1, errorIndex=2, done=0, no further requests.
5. DELAY entry ticks=3, DELAY_UNIT=4 → 12 cycles (±1 FSM cycle) between the previous rspValid and the next reqValid. With ticks=0, no gap beyond the FETCH cycle.
6. start pulse while busy → ignored. start after error → done/error cleared, sequence reruns from entry 0. Reset asserted during WAIT_RSP → all outputs at reset values asynchronously.
